fifo_sched_ctrl: RTL and testbench

Scheduler and arbiter for the shared `fifo_buffer` instance. It arbitrates `NREQ` producers, using round-robin, onto the FIFO's single write port. It drains the FIFO into a one-word valid/ready output register for the consumer. Reads and writes are interleaved fairly because the FIFO performs only one operation per clock. It sits between the producer logic and the FIFO, and owns all FIFO control pins.

---
 rtl/fifo_sched_ctrl.sv | 145 ++++++++++++++
 tb/tb_fifo_sched_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sched_ctrl.sv
// Round-robin write arbiter and read scheduler for a single-port-per-cycle FIFO,
// draining into a one-word valid/ready output register. Optional flag check: FIFO_SCHED_FLAG_CHECK_EN.
module fifo_sched_ctrl #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic                    sys_clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         ack,
    output logic [WIDTH-1:0]        m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [WIDTH-1:0]        fifo_din,
    output logic                    fifo_wr,
    output logic                    fifo_rd,
    output logic                    fifo_en,
    output logic                    fifo_rst_n,
    input  logic [WIDTH-1:0]        fifo_dout,
    input  logic                    fifo_empty,
    output logic                    flag_err,
    output logic [1:0]              dbg_state
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_RDW} state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     level_q;
    logic [PW-1:0]     rr_ptr_q, gnt_q, gnt_idx, idx;
    logic              gnt_any;
    logic [WIDTH-1:0]  gnt_data, din_q, m_data_q;
    logic              m_valid_q;
    logic              last_op_q;      // 1: last completed op was a write
    logic              wr_ok, rd_ok;

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        gnt_idx  = rr_ptr_q;
        gnt_any  = 1'b0;
        idx      = rr_ptr_q;
        gnt_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (idx == PW'(NREQ - 1)) ? '0 : idx + PW'(1);
            if (!gnt_any && req[idx]) begin
                gnt_idx = idx;
                gnt_any = 1'b1;
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_idx == PW'(k)) gnt_data = req_data[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        state_d = state_q;
        wr_ok   = gnt_any && (level_q < LW'(DEPTH));
        rd_ok   = (level_q != '0) && !m_valid_q;
        case (state_q)
            S_IDLE: begin
                if (wr_ok && rd_ok)  state_d = last_op_q ? S_RD : S_WR;
                else if (wr_ok)      state_d = S_WR;
                else if (rd_ok)      state_d = S_RD;
            end
            S_WR:    state_d = S_IDLE;
            S_RD:    state_d = S_RDW;
            S_RDW:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output handshake: a word transfers on any cycle where m_valid && m_ready;
    // m_data holds steady while m_valid is high and m_valid never drops without m_ready.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            level_q   <= '0;
            rr_ptr_q  <= PW'(NREQ - 1);
            gnt_q     <= '0;
            din_q     <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            last_op_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && state_d == S_WR) begin
                gnt_q    <= gnt_idx;
                din_q    <= gnt_data;
                rr_ptr_q <= gnt_idx;
            end
            if (m_valid_q && m_ready) m_valid_q <= 1'b0;
            case (state_q)
                S_WR: begin
                    level_q   <= level_q + LW'(1);
                    last_op_q <= 1'b1;
                end
                S_RD: level_q <= level_q - LW'(1);
                S_RDW: begin
                    m_data_q  <= fifo_dout;
                    m_valid_q <= 1'b1;
                    last_op_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Strobes are gated by rst so an asserted reset aborts a WR without an ack.
    assign ack        = (state_q == S_WR && !rst) ? (NREQ'(1) << gnt_q) : '0;
    assign fifo_wr    = (state_q == S_WR) && !rst;
    assign fifo_rd    = (state_q == S_RD) && !rst;
    assign fifo_din   = rst ? '0 : din_q;
    assign fifo_en    = 1'b1;
    assign fifo_rst_n = ~rst;
    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q && !rst;
    assign dbg_state  = state_q;

`ifdef FIFO_SCHED_FLAG_CHECK_EN
    logic idle_seen_q, flag_err_q;

    // The FIFO's count lags one cycle, so compare only on the second idle cycle onward.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            idle_seen_q <= 1'b0;
            flag_err_q  <= 1'b0;
        end else begin
            idle_seen_q <= (state_q == S_IDLE);
            if (state_q == S_IDLE && idle_seen_q && (fifo_empty != (level_q == '0)))
                flag_err_q <= 1'b1;
        end
    end

    assign flag_err = flag_err_q;
`else
    logic unused_fifo_empty;
    assign unused_fifo_empty = fifo_empty;
    assign flag_err          = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sched_ctrl.sv
// Directed bench for fifo_sched_ctrl with a behavioural FIFO and a queue-based scoreboard.
module tb_fifo_sched_ctrl;

    localparam int NREQ  = 2;
    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int PW    = 1;

    logic                  sys_clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      m_data;
    logic                  m_valid;
    logic                  m_ready = 1'b0;
    logic [WIDTH-1:0]      fifo_din;
    logic                  fifo_wr, fifo_rd, fifo_en, fifo_rst_n;
    logic [WIDTH-1:0]      fifo_dout = '0;
    logic                  fifo_empty;
    logic                  flag_err;
    logic [1:0]            dbg_state;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    logic rec_en = 1'b0;
    logic op_q[$];
    logic [WIDTH-1:0]      exp_q[$];
    logic [NREQ+WIDTH-1:0] ack_q[$];

    logic [WIDTH-1:0] fq[$];
    logic model_empty = 1'b1;
    logic force_empty = 1'b0;
    assign fifo_empty = model_empty | force_empty;

    fifo_sched_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .sys_clk(sys_clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .fifo_din(fifo_din), .fifo_wr(fifo_wr), .fifo_rd(fifo_rd), .fifo_en(fifo_en),
        .fifo_rst_n(fifo_rst_n), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .flag_err(flag_err), .dbg_state(dbg_state)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural FIFO: registered read data, registered empty flag.
    always @(posedge sys_clk) begin
        if (!fifo_rst_n) begin
            fq.delete();
            fifo_dout   <= '0;
            model_empty <= 1'b1;
        end else begin
            if (fifo_wr && fifo_en) begin
                if (fq.size() >= DEPTH) begin
                    checks++; errors++;
                    $display("FAIL fifo_overflow: write with %0d words stored", fq.size());
                end else fq.push_back(fifo_din);
            end
            if (fifo_rd && fifo_en) begin
                if (fq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL fifo_underflow: read while empty");
                end else fifo_dout <= fq.pop_front();
            end
            model_empty <= (fq.size() == 0);
        end
    end

    // Monitor: pops expected writes and output words as the DUT presents them.
    always @(negedge sys_clk) begin
        logic [NREQ+WIDTH-1:0] ew;
        logic [WIDTH-1:0]      ed;
        if (!rst) begin
            if (fifo_wr || (ack != '0)) begin
                if (ack_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: ack=%b din=%0h", ack, fifo_din);
                end else begin
                    ew = ack_q.pop_front();
                    chk("write_ack_din", 32'({fifo_wr, ack, fifo_din}), 32'({1'b1, ew}));
                end
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output: m_data=%0h", m_data);
                end else begin
                    ed = exp_q.pop_front();
                    chk("m_data", 32'(m_data), 32'(ed));
                end
            end
            if (fifo_rd) rd_cnt++;
            if (rec_en && fifo_wr) op_q.push_back(1'b1);
            if (rec_en && fifo_rd) op_q.push_back(1'b0);
`ifndef FIFO_SCHED_FLAG_CHECK_EN
            chk("flag_err_tied", 32'(flag_err), 32'd0);
`endif
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        req = '0;
        for (int i = 0; i < n; i++) tick();
        exp_q.delete();
        ack_q.delete();
        rst = 1'b0;
    endtask

    task automatic put(input logic [PW-1:0] k, input logic [WIDTH-1:0] d);
        int n;
        req_data[k*WIDTH +: WIDTH] = d;
        req[k] = 1'b1;
        ack_q.push_back({NREQ'(1) << k, d});
        exp_q.push_back(d);
        n = 0;
        do begin
            tick();
            n++;
        end while (!ack[k] && n < 50);
        chk("put_ack", 32'(ack[k]), 32'd1);
        req[k] = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 4; i++) tick();
    endtask

    initial begin
        int n, acks, base;

        // Reset values while rst is held.
        tick(); tick();
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_fifo_wr", 32'(fifo_wr), 32'd0);
        chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        chk("rst_fifo_en", 32'(fifo_en), 32'd1);
        chk("rst_fifo_rst_n", 32'(fifo_rst_n), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_fifo_din", 32'(fifo_din), 32'd0);
        chk("rst_flag_err", 32'(flag_err), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;
        #1;
        chk("fifo_rst_n_released", 32'(fifo_rst_n), 32'd1);
        tick();

        // Single write: ack one cycle after req, m_valid four cycles after the write cycle.
        m_ready = 1'b1;
        req_data[7:0] = 8'hA5;
        req = 2'b01;
        ack_q.push_back({2'b01, 8'hA5});
        exp_q.push_back(8'hA5);
        tick();
        chk("single_ack_latency", 32'(ack), 32'h1);
        chk("single_fifo_wr", 32'(fifo_wr), 32'd1);
        req = '0;
        n = 0;
        while (!m_valid && n < 20) begin
            tick();
            n++;
        end
        chk("single_mvalid_latency", 32'(n), 32'd4);
        chk("single_m_data", 32'(m_data), 32'hA5);
        wait_drain("single_drain");

        // Round-robin with both requesters held and the consumer stalled.
        do_reset(2);
        tick();
        m_ready  = 1'b0;
        base     = rd_cnt;
        req_data = {8'h22, 8'h11};
        req      = 2'b11;
        for (int i = 0; i < 9; i++) begin
            ack_q.push_back((i % 2 == 0) ? {2'b01, 8'h11} : {2'b10, 8'h22});
            exp_q.push_back((i % 2 == 0) ? 8'h11 : 8'h22);
        end
        for (int i = 0; i < 40; i++) tick();
        chk("rr_all_writes", 32'(ack_q.size()), 32'd0);
        chk("rr_one_read", 32'(rd_cnt - base), 32'd1);
        chk("rr_m_valid", 32'(m_valid), 32'd1);
        chk("rr_m_data", 32'(m_data), 32'h11);
        req = '0;
        m_ready = 1'b1;
        wait_drain("rr_drain");

        // Fairness: three words stored plus one waiting, then continuous writes.
        m_ready = 1'b0;
        put(1'b0, 8'hC1);
        put(1'b0, 8'hC2);
        put(1'b0, 8'hC3);
        put(1'b0, 8'hC4);
        for (int i = 0; i < 5; i++) tick();
        chk("fair_pre_m_data", 32'(m_data), 32'hC1);
        rec_en  = 1'b1;
        m_ready = 1'b1;
        req_data[7:0] = 8'h5C;
        req = 2'b01;
        for (int i = 0; i < 4; i++) begin
            ack_q.push_back({2'b01, 8'h5C});
            exp_q.push_back(8'h5C);
        end
        acks = 0;
        n = 0;
        while (acks < 4 && n < 100) begin
            tick();
            n++;
            if (ack[0]) begin
                acks++;
                if (acks == 4) req = '0;
            end
        end
        chk("fair_acks", 32'(acks), 32'd4);
        wait_drain("fair_drain");
        rec_en = 1'b0;
        for (int i = 0; i < 8; i++)
            chk("fair_op_order", (i < op_q.size()) ? 32'(op_q[i]) : 32'd2, (i % 2 == 0) ? 32'd1 : 32'd0);

        // Backpressure: one read only, stable m_data, one-cycle pop releases the next read.
        m_ready = 1'b0;
        base = rd_cnt;
        put(1'b0, 8'h31);
        put(1'b0, 8'h32);
        put(1'b0, 8'h33);
        put(1'b0, 8'h34);
        for (int i = 0; i < 10; i++) tick();
        chk("bp_one_read", 32'(rd_cnt - base), 32'd1);
        chk("bp_m_valid", 32'(m_valid), 32'd1);
        chk("bp_m_data", 32'(m_data), 32'h31);
        for (int i = 0; i < 5; i++) tick();
        chk("bp_m_data_stable", 32'(m_data), 32'h31);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("bp_next_read", 32'(rd_cnt - base), 32'd2);
        chk("bp_next_valid", 32'(m_valid), 32'd1);
        chk("bp_next_data", 32'(m_data), 32'h32);
        m_ready = 1'b1;
        wait_drain("bp_drain");

        // Reset while in WR: no ack, state cleared, requester 0 wins next.
        m_ready = 1'b0;
        put(1'b0, 8'h99);
        for (int i = 0; i < 6; i++) tick();
        chk("abort_pre_valid", 32'(m_valid), 32'd1);
        req_data[7:0] = 8'h77;
        req = 2'b01;
        tick();
        chk("abort_in_wr", 32'(dbg_state), 32'd1);
        rst = 1'b1;
        req = '0;
        #1;
        chk("abort_no_ack", 32'(ack), 32'd0);
        chk("abort_no_wr", 32'(fifo_wr), 32'd0);
        do_reset(2);
        chk("abort_m_valid", 32'(m_valid), 32'd0);
        chk("abort_m_data", 32'(m_data), 32'd0);
        chk("abort_state", 32'(dbg_state), 32'd0);
        m_ready  = 1'b1;
        req_data = {8'hBB, 8'hAA};
        req      = 2'b11;
        ack_q.push_back({2'b01, 8'hAA});
        ack_q.push_back({2'b10, 8'hBB});
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'hBB);
        n = 0;
        while (req != '0 && n < 60) begin
            tick();
            n++;
            if (ack[0]) req[0] = 1'b0;
            if (ack[1]) req[1] = 1'b0;
        end
        chk("post_reset_writes", 32'(req), 32'd0);
        wait_drain("post_reset_drain");

`ifdef FIFO_SCHED_FLAG_CHECK_EN
        // Level 2 in idle with the empty flag forced high.
        m_ready = 1'b0;
        put(1'b0, 8'hE1);
        put(1'b0, 8'hE2);
        put(1'b0, 8'hE3);
        for (int i = 0; i < 6; i++) tick();
        chk("flag_clean", 32'(flag_err), 32'd0);
        force_empty = 1'b1;
        tick();
        chk("flag_set", 32'(flag_err), 32'd1);
        force_empty = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("flag_sticky", 32'(flag_err), 32'd1);
        do_reset(2);
        chk("flag_cleared", 32'(flag_err), 32'd0);
        for (int i = 0; i < 4; i++) tick();
`endif

        chk("final_ack_q", 32'(ack_q.size()), 32'd0);
        chk("final_exp_q", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
